// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequencing control unit: opcodes, FSM states,
// decoder output bundle and parameter defaults.
package ctrl_pkg;

    localparam int IW_DEF     = 9;
    localparam int OPW_DEF    = 4;
    localparam int LD_LAT_DEF = 1;
    localparam int CW_DEF     = 16;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_MOV   = 4'h1;
    localparam logic [3:0] OP_PULL  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_SHL   = 4'h4;
    localparam logic [3:0] OP_SHR   = 4'h5;
    localparam logic [3:0] OP_ADD   = 4'h6;
    localparam logic [3:0] OP_ADDC  = 4'h7;
    localparam logic [3:0] OP_SUB   = 4'h8;
    localparam logic [3:0] OP_SUBC  = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BTR   = 4'hB;
    localparam logic [3:0] OP_GT    = 4'hC;
    localparam logic [3:0] OP_FIRST = 4'hD;
    localparam logic [3:0] OP_LAST  = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LDWAIT = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    // Per-opcode action bundle produced by the decoder, gated by the FSM.
    typedef struct packed {
        logic reg_wr;
        logic mem_wr;
        logic is_load;
        logic set_zc;
        logic set_t;
        logic is_beq;
        logic is_btr;
        logic is_halt;
    } dec_t;

endpackage

// File: rtl/ctrl_dec.sv
// Combinational opcode decoder for non-immediate instructions.
module ctrl_dec
    import ctrl_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] opcode,
    output dec_t           dec
);

    // Opcode to action bundle; unlisted encodings do nothing.
    always_comb begin
        dec = '0;
        case (opcode)
            OPW'(OP_LOAD):  dec.is_load = 1'b1;
            OPW'(OP_MOV),
            OPW'(OP_PULL):  dec.reg_wr  = 1'b1;
            OPW'(OP_STORE): dec.mem_wr  = 1'b1;
            OPW'(OP_SHL),
            OPW'(OP_SHR),
            OPW'(OP_ADD),
            OPW'(OP_ADDC),
            OPW'(OP_SUB),
            OPW'(OP_SUBC): begin
                dec.reg_wr = 1'b1;
                dec.set_zc = 1'b1;
            end
            OPW'(OP_BEQ):   dec.is_beq  = 1'b1;
            OPW'(OP_BTR):   dec.is_btr  = 1'b1;
            OPW'(OP_GT),
            OPW'(OP_FIRST),
            OPW'(OP_LAST):  dec.set_t   = 1'b1;
            OPW'(OP_HALT):  dec.is_halt = 1'b1;
            default:        dec = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Run/halt sequencer for the accumulator core.
//   state  | meaning
//   IDLE   | after reset, waiting for Start
//   RUN    | executing one instruction per cycle
//   LDWAIT | load in flight, PC held until data returns
//   HALTED | halt retired, Done high, waiting for Start
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IW     = IW_DEF,
    parameter int OPW    = OPW_DEF,
    parameter int LD_LAT = LD_LAT_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic [IW-1:0]  Instruction,
    input  logic           AluZero,
    input  logic           AluCond,
    input  logic           AluCarry,
    output logic           PcRst,
    output logic           PcEn,
    output logic           BranchTaken,
    output logic [OPW-1:0] AluOp,
    output logic           ImmEn,
    output logic           RegWrEn,
    output logic           MemRdEn,
    output logic           MemWrEn,
    output logic           CarryQ,
    output logic           Done,
    output logic [CW-1:0]  InstCnt
);

    ctrl_state_t state, state_next;
    dec_t        dec;
    logic        z_q, t_q, c_q;
    logic [2:0]  wait_q;
    logic [CW-1:0] cnt_q;
    logic        zc_we, t_we, wait_load, wait_dec, cnt_clr, cnt_inc;
    logic        unused_bits;

    assign AluOp       = Instruction[IW-2 -: OPW];
    assign CarryQ      = c_q;
    assign InstCnt     = cnt_q;
    // Operand bits below the opcode are consumed by the datapath, not here.
    assign unused_bits = ^Instruction[IW-OPW-2:0];

    ctrl_dec #(.OPW(OPW)) u_dec (
        .opcode (AluOp),
        .dec    (dec)
    );

    // Next state and state-gated enables.
    always_comb begin
        state_next  = state;
        PcRst       = 1'b0;
        PcEn        = 1'b0;
        BranchTaken = 1'b0;
        ImmEn       = 1'b0;
        RegWrEn     = 1'b0;
        MemRdEn     = 1'b0;
        MemWrEn     = 1'b0;
        Done        = 1'b0;
        zc_we       = 1'b0;
        t_we        = 1'b0;
        wait_load   = 1'b0;
        wait_dec    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_RUN;
                    PcRst      = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            ST_RUN: begin
                if (Instruction[IW-1]) begin
                    ImmEn   = 1'b1;
                    RegWrEn = 1'b1;
                    PcEn    = 1'b1;
                end else if (dec.is_halt) begin
                    state_next = ST_HALTED;
                    cnt_inc    = 1'b1;
                end else if (dec.is_load) begin
                    MemRdEn = 1'b1;
                    if (LD_LAT == 0) begin
                        RegWrEn = 1'b1;
                        PcEn    = 1'b1;
                    end else begin
                        state_next = ST_LDWAIT;
                        wait_load  = 1'b1;
                    end
                end else begin
                    PcEn        = 1'b1;
                    RegWrEn     = dec.reg_wr;
                    MemWrEn     = dec.mem_wr;
                    zc_we       = dec.set_zc;
                    t_we        = dec.set_t;
                    // Branches resolve on the registered flags only.
                    BranchTaken = (dec.is_beq & z_q) | (dec.is_btr & t_q);
                end
            end
            ST_LDWAIT: begin
                MemRdEn = 1'b1;
                if (wait_q == 3'd1) begin
                    RegWrEn    = 1'b1;
                    PcEn       = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            ST_HALTED: begin
                Done = 1'b1;
                if (Start) begin
                    state_next = ST_RUN;
                    PcRst      = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (PcEn) cnt_inc = 1'b1;
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Zero/True/Carry condition registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            z_q <= 1'b0;
            t_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            if (zc_we) begin
                z_q <= AluZero;
                c_q <= AluCarry;
            end
            if (t_we) t_q <= AluCond;
        end
    end

    // Load-latency down-counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n)       wait_q <= 3'd0;
        else if (wait_load) wait_q <= 3'(LD_LAT);
        else if (wait_dec)  wait_q <= wait_q - 3'd1;
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n)                   cnt_q <= '0;
        else if (cnt_clr)               cnt_q <= '0;
        else if (cnt_inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: main instance with a two-cycle load
// latency, plus a narrow-counter instance with zero load latency.
module tb_ctrl_seq;
    import ctrl_pkg::*;

    localparam logic [8:0] E_RST = 9'h100;
    localparam logic [8:0] E_PC  = 9'h080;
    localparam logic [8:0] E_BR  = 9'h040;
    localparam logic [8:0] E_IMM = 9'h020;
    localparam logic [8:0] E_RW  = 9'h010;
    localparam logic [8:0] E_MR  = 9'h008;
    localparam logic [8:0] E_MW  = 9'h004;
    localparam logic [8:0] E_DN  = 9'h002;
    localparam logic [8:0] E_C   = 9'h001;

    typedef struct {
        logic [8:0] en;
        int         cnt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n, Start, AluZero, AluCond, AluCarry;
    logic [8:0]  Instruction;

    logic        a_pc_rst, a_pc_en, a_br, a_imm, a_rw, a_mr, a_mw, a_cq, a_done;
    logic [3:0]  a_op;
    logic [15:0] a_cnt;
    logic        b_pc_rst, b_pc_en, b_br, b_imm, b_rw, b_mr, b_mw, b_cq, b_done;
    logic [3:0]  b_op;
    logic [1:0]  b_cnt;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;

    ctrl_seq #(.IW(9), .OPW(4), .LD_LAT(2), .CW(16)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instruction(Instruction),
        .AluZero(AluZero), .AluCond(AluCond), .AluCarry(AluCarry),
        .PcRst(a_pc_rst), .PcEn(a_pc_en), .BranchTaken(a_br), .AluOp(a_op),
        .ImmEn(a_imm), .RegWrEn(a_rw), .MemRdEn(a_mr), .MemWrEn(a_mw),
        .CarryQ(a_cq), .Done(a_done), .InstCnt(a_cnt)
    );

    ctrl_seq #(.IW(9), .OPW(4), .LD_LAT(0), .CW(2)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instruction(Instruction),
        .AluZero(AluZero), .AluCond(AluCond), .AluCarry(AluCarry),
        .PcRst(b_pc_rst), .PcEn(b_pc_en), .BranchTaken(b_br), .AluOp(b_op),
        .ImmEn(b_imm), .RegWrEn(b_rw), .MemRdEn(b_mr), .MemWrEn(b_mw),
        .CarryQ(b_cq), .Done(b_done), .InstCnt(b_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ins(input logic [3:0] op);
        return {1'b0, op, 4'h0};
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare before the edge.
    task automatic cyc(input logic [8:0] instr, input logic st, input logic az,
                       input logic ac, input logic acy, input logic [8:0] e,
                       input int cnt, input int cb = -1, input int eb = -1);
        exp_t r;
        logic [2:0] ebv;
        Instruction = instr;
        Start       = st;
        AluZero     = az;
        AluCond     = ac;
        AluCarry    = acy;
        r.en  = e;
        r.cnt = cnt;
        sbq.push_back(r);
        #3;
        r = sbq.pop_front();
        chk($sformatf("c%0d_pc_rst", ncyc), a_pc_rst, r.en[8]);
        chk($sformatf("c%0d_pc_en", ncyc),  a_pc_en,  r.en[7]);
        chk($sformatf("c%0d_branch", ncyc), a_br,     r.en[6]);
        chk($sformatf("c%0d_imm", ncyc),    a_imm,    r.en[5]);
        chk($sformatf("c%0d_reg_wr", ncyc), a_rw,     r.en[4]);
        chk($sformatf("c%0d_mem_rd", ncyc), a_mr,     r.en[3]);
        chk($sformatf("c%0d_mem_wr", ncyc), a_mw,     r.en[2]);
        chk($sformatf("c%0d_done", ncyc),   a_done,   r.en[1]);
        chk($sformatf("c%0d_carry", ncyc),  a_cq,     r.en[0]);
        chk($sformatf("c%0d_inst_cnt", ncyc), a_cnt,  r.cnt);
        chk($sformatf("c%0d_alu_op", ncyc), a_op,     instr[7:4]);
        if (cb >= 0) chk($sformatf("c%0d_b_inst_cnt", ncyc), b_cnt, cb);
        if (eb >= 0) begin
            ebv = eb[2:0];
            chk($sformatf("c%0d_b_pc_rw_mr", ncyc), {b_pc_en, b_rw, b_mr}, ebv);
        end
        ncyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_cycle();
        Reset_n = 1'b0;
        Start   = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Instruction = '0;
        AluZero = 1'b0; AluCond = 1'b0; AluCarry = 1'b0;
        @(posedge Clk);
        #1;
        // reset held: IDLE outputs
        cyc(ins(OP_ADD), 0, 0, 0, 0, 9'h000, 0);
        Reset_n = 1'b1;
        cyc(ins(OP_ADD),   0, 0, 0, 0, 9'h000, 0);
        cyc(ins(OP_ADD),   1, 0, 0, 0, E_RST, 0);
        cyc(ins(OP_ADD),   0, 1, 0, 1, E_PC | E_RW, 0);
        cyc(ins(OP_BEQ),   0, 0, 0, 0, E_PC | E_BR | E_C, 1);
        cyc(ins(OP_GT),    0, 0, 0, 0, E_PC | E_C, 2);
        cyc(ins(OP_BTR),   0, 0, 1, 0, E_PC | E_C, 3);
        cyc(ins(OP_FIRST), 0, 0, 1, 0, E_PC | E_C, 4);
        cyc(ins(OP_BTR),   0, 0, 0, 0, E_PC | E_BR | E_C, 5);
        cyc(ins(OP_SUB),   0, 0, 0, 0, E_PC | E_RW | E_C, 6);
        cyc(ins(OP_BEQ),   0, 1, 0, 0, E_PC, 7);
        cyc(9'h1A5,        0, 0, 0, 0, E_PC | E_IMM | E_RW, 8);
        cyc(ins(OP_STORE), 0, 0, 0, 0, E_PC | E_MW, 9);
        // two-cycle load latency
        cyc(ins(OP_LOAD),  0, 0, 0, 0, E_MR, 10);
        cyc(ins(OP_LOAD),  0, 0, 0, 0, E_MR, 10);
        cyc(ins(OP_LOAD),  0, 0, 0, 0, E_MR | E_RW | E_PC, 10);
        // Start in RUN is ignored
        cyc(ins(OP_MOV),   1, 0, 0, 0, E_PC | E_RW, 11);
        cyc(ins(OP_ADD),   0, 1, 0, 1, E_PC | E_RW, 12);
        cyc(ins(OP_HALT),  0, 0, 0, 0, E_C, 13);
        for (int i = 0; i < 10; i++)
            cyc(ins(OP_ADD), 0, 0, 0, 0, E_DN | E_C, 14);
        cyc(ins(OP_BEQ),   1, 0, 0, 0, E_RST | E_DN | E_C, 14);
        cyc(ins(OP_BEQ),   0, 0, 0, 0, E_PC | E_BR | E_C, 0);
        cyc(ins(OP_LOAD),  0, 0, 0, 0, E_MR | E_C, 1);
        // reset while in LDWAIT
        reset_cycle();
        cyc(ins(OP_BEQ),   0, 0, 0, 0, 9'h000, 0);
        cyc(ins(OP_BEQ),   1, 0, 0, 0, E_RST, 0);
        cyc(ins(OP_BEQ),   0, 0, 0, 0, E_PC, 0);
        cyc(ins(OP_BTR),   0, 0, 0, 0, E_PC, 1);
        // counter saturation on the narrow instance, single-cycle load there
        reset_cycle();
        cyc(ins(OP_MOV),   1, 0, 0, 0, E_RST, 0, 0);
        cyc(ins(OP_MOV),   0, 0, 0, 0, E_PC | E_RW, 0, 0);
        cyc(ins(OP_MOV),   0, 0, 0, 0, E_PC | E_RW, 1, 1);
        cyc(ins(OP_MOV),   0, 0, 0, 0, E_PC | E_RW, 2, 2);
        cyc(ins(OP_MOV),   0, 0, 0, 0, E_PC | E_RW, 3, 3);
        cyc(ins(OP_LOAD),  0, 0, 0, 0, E_MR, 4, 3, 7);
        cyc(ins(OP_MOV),   0, 0, 0, 0, E_MR, 4, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Sequencing control unit for the 9-bit accumulator-style core: decodes the fetched instruction, owns the run/halt state machine, inserts load-latency stalls, holds the Zero/True/Carry condition registers and resolves `beq`/`btr`. It sits between the instruction ROM and the program counter, register file, ALU and data memory. It generalises the combinational opcode decoder with a parametrised instruction width, load latency and retire counter.

## Interface
Parameters:
- `IW`, 9: instruction width; bit `IW-1` selects immediate-set type.
- `OPW`, 4: opcode width; opcode = `Instruction[IW-2 -: OPW]`.
- `LD_LAT`, 1: data-memory read latency in cycles (0..7).
- `CW`, 16: retire-counter width.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `Start` in 1: level, sampled each cycle; begins or restarts execution.
- `Instruction` in IW: current instruction from instruction ROM.
- `AluZero` in 1: ALU result-is-zero.
- `AluCond` in 1: ALU compare/bit-test result.
- `AluCarry` in 1: ALU carry/borrow out.
- `PcRst` out 1: PC clear, one-cycle pulse.
- `PcEn` out 1: PC advance this cycle.
- `BranchTaken` out 1: PC loads branch target instead of +1 (only with `PcEn`).
- `AluOp` out OPW: opcode pass-through.
- `ImmEn` out 1: immediate-set instruction.
- `RegWrEn`, `MemRdEn`, `MemWrEn` out 1 each.
- `CarryQ` out 1: carry register to ALU.
- `Done` out 1: core halted.
- `InstCnt` out CW: retired-instruction count.

## Operation
- States: IDLE, RUN, LDWAIT, HALTED.
- IDLE: all enables 0. `Start`=1 → RUN, `PcRst`=1 that cycle, `InstCnt`←0.
- RUN, top bit 1: `ImmEn`, `RegWrEn`, `PcEn`.
- RUN, top bit 0, opcode 0x0–0xF = load, mov, pull, store, shl, shr, add, addc, sub, subc, beq, btr, gt, first, last, halt.
  - mov/pull/shl..subc: `RegWrEn`, `PcEn`.
  - shl..subc: Z←`AluZero`, C←`AluCarry` at cycle end.
  - store: `MemWrEn`, `PcEn`.
  - gt/first/last: T←`AluCond`, `PcEn`; no register write.
  - beq: `PcEn`, `BranchTaken`=Z. btr: `PcEn`, `BranchTaken`=T. Uses the registered flag, never the live input.
  - load, `LD_LAT`=0: `MemRdEn`, `RegWrEn`, `PcEn` in one cycle.
  - load, `LD_LAT`>0: `MemRdEn` in RUN, `PcEn`=0, → LDWAIT with wait counter = `LD_LAT`. LDWAIT holds `MemRdEn`=1 and `PcEn`=0 and decrements the counter. On the cycle counter=1: `RegWrEn`, `PcEn`, → RUN.
  - halt: no enables, → HALTED.
- HALTED: `Done`=1, enables 0, flags held. `Start`=1 → RUN with `PcRst` pulse and `InstCnt`←0; flags are not cleared.
- `Start` in RUN/LDWAIT is ignored.
- `InstCnt` increments on every cycle with `PcEn`=1, plus once on halt. It saturates at all-ones.
- `AluOp` = opcode field in every state; it is only meaningful in RUN/LDWAIT.

## Timing
- Enables are combinational from state + `Instruction`. State, Z/T/C, wait counter and `InstCnt` are registered.
- Reset (`Reset_n`=0 at edge), from any state including mid-LDWAIT: state IDLE, Z=T=C=0, counter 0, `InstCnt`=0. All outputs 0 except `AluOp` (tracks input).
- Flag written by instruction N is visible to a branch at N+1.
- Load costs 1+`LD_LAT` cycles; all others cost 1.
- `Done` asserts the cycle after halt is decoded.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams `OP_LOAD`..`OP_HALT`;
  - state enum `ctrl_state_t`;
  - parameter defaults.
- Sub-module `ctrl_dec`: a purely combinational opcode → enable-vector decoder. `ctrl_seq` gates that vector by state and holds all sequential logic.

## Test plan
- Reset then `Start`: `PcRst` pulse in the same cycle, state RUN; `add` with `AluZero`=1 then `beq` → `BranchTaken`=1, `PcEn`=1, `InstCnt`=2.
- `LD_LAT`=2, load: `MemRdEn` high 3 cycles, `PcEn` low 2 cycles then high with `RegWrEn`; `InstCnt`+1.
- `gt` with `AluCond`=0 then `btr` → `BranchTaken`=0. `first` with `AluCond`=1 then `btr` → 1.
- `halt`: `Done`=1 next cycle, PcEn stays 0 for 10 cycles. `Start` → `PcRst`, `InstCnt`=0, Z unchanged.
- `Reset_n`=0 during LDWAIT: next cycle IDLE, all enables 0, flags 0; `Start` mid-RUN has no effect.
- `CW`=2: 5 retired instructions → `InstCnt` saturates at 3.
